// File: rtl/frame_pkg.sv
// Shared types, constants and index mapping for the frame read-out path.
// Half modes walk two columns of the 4x4 grid; full mode walks all 16 words in order.
package frame_pkg;

    localparam int WORD_W    = 32;
    localparam int NUM_WORDS = 16;

    localparam logic [1:0] MODE_SMALL = 2'b00;
    localparam logic [1:0] MODE_BIG   = 2'b01;
    localparam logic [1:0] MODE_FULL  = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [WORD_W-1:0] word_t;

    // mode[1] set means full frame (10 and 11); otherwise mode[0] picks the column pair.
    function automatic logic [3:0] next_index(input logic [1:0] mode, input logic [3:0] cnt);
        if (mode[1]) begin
            return cnt;
        end
        return {cnt[2:1], mode[0], cnt[0]};
    endfunction

endpackage

// File: rtl/frame_if.sv
// Word stream from the frame reader to a single-word consumer.
// valid/ready handshake; payload is data, grid index and last marker.
interface frame_if;
    import frame_pkg::*;

    logic       out_valid;
    logic       out_ready;
    word_t      out_data;
    logic [3:0] out_index;
    logic       out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_index,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_index,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/frame_index_gen.sv
// Purpose: map read-out mode and word counter to grid index and last flag.
// Latency: purely combinational.
// Backpressure: none; the caller holds cnt stable while the consumer stalls.
module frame_index_gen
    import frame_pkg::*;
(
    input  logic [1:0] mode,
    input  logic [3:0] cnt,
    output logic [3:0] index,
    output logic       last
);

    always_comb begin
        index = next_index(mode, cnt);
        last  = mode[1] ? (cnt == 4'd15) : (cnt[2:0] == 3'd7);
    end

endmodule

// File: rtl/frame_reader.sv
// Purpose: snapshot the 16-word frame on start and stream the selected words out.
// Latency: first word valid the cycle after start is sampled; one word per cycle with ready high.
// Backpressure: payload holds while out_valid && !out_ready; abort drops the stream at the next edge.
module frame_reader
    import frame_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  word_t      frame_0_in,
    input  word_t      frame_1_in,
    input  word_t      frame_2_in,
    input  word_t      frame_3_in,
    input  word_t      frame_4_in,
    input  word_t      frame_5_in,
    input  word_t      frame_6_in,
    input  word_t      frame_7_in,
    input  word_t      frame_8_in,
    input  word_t      frame_9_in,
    input  word_t      frame_10_in,
    input  word_t      frame_11_in,
    input  word_t      frame_12_in,
    input  word_t      frame_13_in,
    input  word_t      frame_14_in,
    input  word_t      frame_15_in,
    input  logic       start,
    input  logic [1:0] mode,
    input  logic       abort,
    frame_if.master    stream,
    output logic       busy,
    output logic       done
);

    state_t     state_q, state_d;
    logic [3:0] cnt_q;
    logic [1:0] mode_q;
    word_t      snap_q [NUM_WORDS];
    word_t      frame_in [NUM_WORDS];
    logic [3:0] idx;
    logic       last;
    logic       in_send;
    logic       xfer;

    assign frame_in[0]  = frame_0_in;
    assign frame_in[1]  = frame_1_in;
    assign frame_in[2]  = frame_2_in;
    assign frame_in[3]  = frame_3_in;
    assign frame_in[4]  = frame_4_in;
    assign frame_in[5]  = frame_5_in;
    assign frame_in[6]  = frame_6_in;
    assign frame_in[7]  = frame_7_in;
    assign frame_in[8]  = frame_8_in;
    assign frame_in[9]  = frame_9_in;
    assign frame_in[10] = frame_10_in;
    assign frame_in[11] = frame_11_in;
    assign frame_in[12] = frame_12_in;
    assign frame_in[13] = frame_13_in;
    assign frame_in[14] = frame_14_in;
    assign frame_in[15] = frame_15_in;

    frame_index_gen u_index_gen (
        .mode  (mode_q),
        .cnt   (cnt_q),
        .index (idx),
        .last  (last)
    );

    assign in_send = (state_q == SEND);
    assign xfer    = in_send && stream.out_ready;

    // Payload is forced to zero outside SEND so idle and reset outputs read as zero.
    assign stream.out_data  = in_send ? snap_q[idx] : '0;
    assign stream.out_index = in_send ? idx : 4'd0;
    assign stream.out_last  = in_send && last;

    always_comb begin
        state_d          = state_q;
        stream.out_valid = 1'b0;
        busy             = 1'b0;
        done             = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                stream.out_valid = 1'b1;
                busy             = 1'b1;
                // abort wins over a same-cycle transfer, so the final word is never counted
                if (abort) begin
                    state_d = IDLE;
                end else if (xfer && last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = !abort;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            mode_q  <= MODE_SMALL;
            for (int i = 0; i < NUM_WORDS; i++) begin
                snap_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start) begin
                cnt_q  <= 4'd0;
                mode_q <= mode;
                for (int i = 0; i < NUM_WORDS; i++) begin
                    snap_q[i] <= frame_in[i];
                end
            end else if (xfer && !abort) begin
                cnt_q <= cnt_q + 4'd1;
            end
        end
    end

endmodule
